// File: rtl/text_line_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : text_line_scheduler
// Description : Renders the resolution banner and lag readout scanline bitmaps
//               into shadow buffers; commits them on line_start.
//               Optional macro TEXT_INVERT_EN: char_data bit7 = inverse video.
// Revision    : 1.0 - initial release
// ============================================================================
module text_line_scheduler #(
   parameter int RES_CHARS = 40,
   parameter int LAG_CHARS = 60,
   parameter int CHAR_AW   = 7
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     line_start,
   input  logic                     res_active,
   input  logic [3:0]               res_row,
   input  logic                     lag_active,
   input  logic [3:0]               lag_row,
   output logic [CHAR_AW-1:0]       char_addr,
   input  logic [7:0]               char_data,
   output logic [11:0]              font_addr,
   input  logic [7:0]               font_data,
   output logic [RES_CHARS*8-1:0]   resolution_line,
   output logic [LAG_CHARS*8-1:0]   lagdisplay_line,
   output logic                     busy,
   output logic                     overrun
);

   localparam int MAX_CHARS = (RES_CHARS > LAG_CHARS) ? RES_CHARS : LAG_CHARS;
   localparam int IDX_W     = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
   localparam logic [IDX_W-1:0]   c_RES_LAST = IDX_W'(RES_CHARS - 1);
   localparam logic [IDX_W-1:0]   c_LAG_LAST = IDX_W'(LAG_CHARS - 1);
   localparam logic [CHAR_AW-1:0] c_LAG_BASE = CHAR_AW'(RES_CHARS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RES_ADDR  = 3'd1,
      S_RES_FONT  = 3'd2,
      S_RES_STORE = 3'd3,
      S_LAG_ADDR  = 3'd4,
      S_LAG_FONT  = 3'd5,
      S_LAG_STORE = 3'd6
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [IDX_W-1:0]         r_idx;
   logic                     r_res_active;
   logic                     r_lag_active;
   logic [3:0]               r_res_row;
   logic [3:0]               r_lag_row;
   logic [RES_CHARS*8-1:0]   r_shadow_res;
   logic [LAG_CHARS*8-1:0]   r_shadow_lag;
   logic [RES_CHARS*8-1:0]   r_res_line;
   logic [LAG_CHARS*8-1:0]   r_lag_line;
   logic [CHAR_AW-1:0]       r_char_addr;
   logic [11:0]              r_font_addr;
   logic                     r_overrun;
   logic [CHAR_AW-1:0]       w_char_addr;
   logic [11:0]              w_font_addr;
   logic [7:0]               w_code;
   logic [7:0]               w_store_byte;

`ifdef TEXT_INVERT_EN
   logic                     r_inv;
   assign w_code       = {1'b0, char_data[6:0]};
   assign w_store_byte = font_data ^ {8{r_inv}};
`else
   assign w_code       = char_data;
   assign w_store_byte = font_data;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Addresses are combinational in their active state and otherwise hold the last driven value.
   always_comb begin
      w_state_nxt = r_state;
      w_char_addr = r_char_addr;
      w_font_addr = r_font_addr;
      case (r_state)
         S_RES_ADDR: begin
            if (!r_res_active) begin
               w_state_nxt = S_LAG_ADDR;
            end else begin
               w_char_addr = CHAR_AW'(r_idx);
               w_state_nxt = S_RES_FONT;
            end
         end
         S_RES_FONT: begin
            w_font_addr = {w_code, r_res_row};
            w_state_nxt = S_RES_STORE;
         end
         S_RES_STORE: begin
            w_state_nxt = (r_idx == c_RES_LAST) ? S_LAG_ADDR : S_RES_ADDR;
         end
         S_LAG_ADDR: begin
            if (!r_lag_active) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_char_addr = c_LAG_BASE + CHAR_AW'(r_idx);
               w_state_nxt = S_LAG_FONT;
            end
         end
         S_LAG_FONT: begin
            w_font_addr = {w_code, r_lag_row};
            w_state_nxt = S_LAG_STORE;
         end
         S_LAG_STORE: begin
            w_state_nxt = (r_idx == c_LAG_LAST) ? S_IDLE : S_LAG_ADDR;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (line_start) begin
         w_state_nxt = S_RES_ADDR;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx        <= '0;
         r_res_active <= 1'b0;
         r_lag_active <= 1'b0;
         r_res_row    <= '0;
         r_lag_row    <= '0;
         r_shadow_res <= '0;
         r_shadow_lag <= '0;
         r_res_line   <= '0;
         r_lag_line   <= '0;
         r_char_addr  <= '0;
         r_font_addr  <= '0;
         r_overrun    <= 1'b0;
`ifdef TEXT_INVERT_EN
         r_inv        <= 1'b0;
`endif
      end else begin
         r_char_addr <= w_char_addr;
         r_font_addr <= w_font_addr;
         r_overrun   <= line_start && (r_state != S_IDLE);
         // A new line always wins over an in-flight store; the partial shadow is committed as is.
         if (line_start) begin
            r_res_line   <= r_shadow_res;
            r_lag_line   <= r_shadow_lag;
            r_res_active <= res_active;
            r_res_row    <= res_row;
            r_lag_active <= lag_active;
            r_lag_row    <= lag_row;
            r_idx        <= '0;
         end else begin
            case (r_state)
               S_RES_ADDR: begin
                  if (!r_res_active) begin
                     r_shadow_res <= '0;
                  end
               end
               S_RES_STORE: begin
                  for (int i = 0; i < RES_CHARS; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        r_shadow_res[(RES_CHARS-1-i)*8 +: 8] <= w_store_byte;
                     end
                  end
                  r_idx <= (r_idx == c_RES_LAST) ? '0 : r_idx + IDX_W'(1);
               end
               S_LAG_ADDR: begin
                  if (!r_lag_active) begin
                     r_shadow_lag <= '0;
                  end
               end
               S_LAG_STORE: begin
                  for (int i = 0; i < LAG_CHARS; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        r_shadow_lag[(LAG_CHARS-1-i)*8 +: 8] <= w_store_byte;
                     end
                  end
                  r_idx <= (r_idx == c_LAG_LAST) ? '0 : r_idx + IDX_W'(1);
               end
`ifdef TEXT_INVERT_EN
               S_RES_FONT, S_LAG_FONT: begin
                  r_inv <= char_data[7];
               end
`endif
               default: begin
               end
            endcase
         end
      end
   end

   assign char_addr       = w_char_addr;
   assign font_addr       = w_font_addr;
   assign resolution_line = r_res_line;
   assign lagdisplay_line = r_lag_line;
   assign busy            = (r_state != S_IDLE);
   assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_text_line_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_text_line_scheduler
// Description : Self-checking bench for text_line_scheduler with memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_line_scheduler;

   localparam int RC = 40;
   localparam int LC = 60;
   localparam int AW = 7;

   logic            clock = 1'b0;
   logic            reset;
   logic            line_start;
   logic            res_active;
   logic [3:0]      res_row;
   logic            lag_active;
   logic [3:0]      lag_row;
   logic [AW-1:0]   char_addr;
   logic [7:0]      char_data;
   logic [11:0]     font_addr;
   logic [7:0]      font_data;
   logic [RC*8-1:0] resolution_line;
   logic [LC*8-1:0] lagdisplay_line;
   logic            busy;
   logic            overrun;

   int total = 0;
   int bad   = 0;
   int mode  = 0;

   typedef struct {
      int         mode;
      bit         ra;
      logic [3:0] rr;
      bit         la;
      logic [3:0] lr;
      int         nbusy;
   } vec_t;

   vec_t vt [6];

   text_line_scheduler #(.RES_CHARS(RC), .LAG_CHARS(LC), .CHAR_AW(AW)) dut (
      .clock           (clock),
      .reset           (reset),
      .line_start      (line_start),
      .res_active      (res_active),
      .res_row         (res_row),
      .lag_active      (lag_active),
      .lag_row         (lag_row),
      .char_addr       (char_addr),
      .char_data       (char_data),
      .font_addr       (font_addr),
      .font_data       (font_data),
      .resolution_line (resolution_line),
      .lagdisplay_line (lagdisplay_line),
      .busy            (busy),
      .overrun         (overrun)
   );

   always #5 clock = ~clock;

   // Mode 0: every char 0x41, only glyph {0x41,3} is 0x18. Mode 1: char = address,
   // glyph = code + row. Mode 2: every char 0xC1 with the mode-0 font.
   function automatic logic [7:0] char_f(int m, int a);
      logic [31:0] av;
      av = a;
      if (m == 1) return av[7:0];
      if (m == 2) return 8'hC1;
      return 8'h41;
   endfunction

   function automatic logic [7:0] font_f(int m, logic [7:0] code, logic [3:0] row);
      if (m == 1) return code + {4'b0, row};
      return (code == 8'h41 && row == 4'd3) ? 8'h18 : 8'h00;
   endfunction

   function automatic logic [479:0] exp_line(int m, bit act, logic [3:0] row, int base, int n);
      logic [479:0] v;
      v = '0;
      if (act) begin
         for (int i = 0; i < n; i++) begin
            v = {v[471:0], font_f(m, char_f(m, base + i), row)};
         end
      end
      return v;
   endfunction

   always @(posedge clock) begin
      char_data <= char_f(mode, int'(char_addr));
      font_data <= font_f(mode, font_addr[11:4], font_addr[3:0]);
   end

   task automatic chk(string nm, logic [479:0] got, logic [479:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(bit ra, logic [3:0] rr, bit la, logic [3:0] lr);
      res_active = ra;
      res_row    = rr;
      lag_active = la;
      lag_row    = lr;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [479:0] last_lag;
      vt[0] = '{0, 1'b1, 4'd3,  1'b0, 4'd0, 121};
      vt[1] = '{1, 1'b1, 4'd5,  1'b1, 4'd2, 300};
      vt[2] = '{1, 1'b0, 4'd0,  1'b0, 4'd0, 2};
      vt[3] = '{1, 1'b0, 4'd0,  1'b1, 4'd7, 181};
      vt[4] = '{1, 1'b1, 4'd15, 1'b0, 4'd0, 121};
      vt[5] = '{1, 1'b1, 4'd0,  1'b1, 4'd0, 300};

      reset = 1'b1; line_start = 1'b0;
      res_active = 1'b0; res_row = '0; lag_active = 1'b0; lag_row = '0;
      repeat (3) tick();
      chk("rst_busy",    480'(busy),            480'(0));
      chk("rst_overrun", 480'(overrun),         480'(0));
      chk("rst_char",    480'(char_addr),       480'(0));
      chk("rst_font",    480'(font_addr),       480'(0));
      chk("rst_res",     480'(resolution_line), 480'(0));
      chk("rst_lag",     lagdisplay_line,       480'(0));
      reset = 1'b0;
      tick();

      last_lag = '0;
      for (int k = 0; k < 6; k++) begin
         mode = vt[k].mode;
         pulse(vt[k].ra, vt[k].rr, vt[k].la, vt[k].lr);
         wait_idle(n);
         chk($sformatf("v%0d_busy", k), 480'(n), 480'(vt[k].nbusy));
         pulse(1'b0, 4'd0, 1'b0, 4'd0);
         chk($sformatf("v%0d_res", k), 480'(resolution_line),
             exp_line(mode, vt[k].ra, vt[k].rr, 0, RC));
         chk($sformatf("v%0d_lag", k), lagdisplay_line,
             exp_line(mode, vt[k].la, vt[k].lr, RC, LC));
         last_lag = lagdisplay_line;
         wait_idle(n);
      end
      chk("lag_first_byte", 480'(last_lag[479:472]), 480'(8'h28));
      chk("lag_last_byte",  480'(last_lag[7:0]),     480'(8'h63));

      // Overrun: second line_start 150 cycles after the first.
      mode = 1;
      pulse(1'b1, 4'd2, 1'b1, 4'd1);
      repeat (149) tick();
      res_active = 1'b1; res_row = 4'd4; lag_active = 1'b0; lag_row = 4'd0;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      chk("ovr_pulse", 480'(overrun),   480'(1));
      chk("ovr_busy",  480'(busy),      480'(1));
      chk("ovr_addr",  480'(char_addr), 480'(0));
      chk("ovr_commit", 480'(resolution_line), exp_line(1, 1'b1, 4'd2, 0, RC));
      tick();
      chk("ovr_single", 480'(overrun), 480'(0));
      wait_idle(n);
      chk("ovr_rest_busy", 480'(n), 480'(120));
      pulse(1'b0, 4'd0, 1'b0, 4'd0);
      chk("ovr_res", 480'(resolution_line), exp_line(1, 1'b1, 4'd4, 0, RC));
      chk("ovr_lag", lagdisplay_line, 480'(0));
      wait_idle(n);

      // Reset 50 cycles into a render, with non-zero lines already committed.
      pulse(1'b1, 4'd5, 1'b1, 4'd5);
      wait_idle(n);
      pulse(1'b1, 4'd5, 1'b1, 4'd5);
      repeat (49) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", 480'(busy),            480'(0));
      chk("mid_rst_res",  480'(resolution_line), 480'(0));
      chk("mid_rst_lag",  lagdisplay_line,       480'(0));
      pulse(1'b1, 4'd5, 1'b1, 4'd5);
      chk("post_rst_res", 480'(resolution_line), 480'(0));
      chk("post_rst_lag", lagdisplay_line,       480'(0));
      wait_idle(n);

`ifdef TEXT_INVERT_EN
      mode = 2;
      pulse(1'b1, 4'd3, 1'b0, 4'd0);
      tick();
      chk("inv_font_addr", 480'(font_addr), 480'({8'h41, 4'd3}));
      wait_idle(n);
      pulse(1'b0, 4'd0, 1'b0, 4'd0);
      chk("inv_res", 480'(resolution_line), 480'({RC{8'hE7}}));
      wait_idle(n);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
